// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
//
// Intruder-alarm controller: exit delay after arming, entry window after
// motion, siren alarm, and a lockout period after too many wrong codes.
// A four-digit keypad code (digit 0 in bits [15:12]) disarms the system.
//
// Optional feature macro: SIREN_TONE_EN
//   defined   : bocina toggles every TONE_HALF cycles while the siren is on,
//               starting high on the first active cycle.
//   undefined : bocina is held at 1 while the siren is on.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   pir_n      in   PIR sensor, 0 = motion (already synchronised)
//   key_valid  in   one-cycle strobe qualifying key_code
//   key_code   in   0x0-0x9 digit, 0xE ENTER, 0xF CLEAR, others ignored
//   arm_req    in   one-cycle arming request
//   alerta     out  alert indicator (ENTRY, ALARM, LOCKOUT)
//   bocina     out  siren drive
//   armed      out  high in EXIT, ARMED, ENTRY, ALARM
//   state_o    out  DISARMED=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4 LOCKOUT=5
// -----------------------------------------------------------------------------
module alarm_sequencer #(
  parameter logic [15:0] CODE         = 16'h1234,
  parameter int unsigned EXIT_CYCLES  = 50000,
  parameter int unsigned ENTRY_CYCLES = 50000,
  parameter int unsigned TONE_HALF    = 25000,
  parameter int unsigned MAX_TRIES    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pir_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       arm_req,
  output logic       alerta,
  output logic       bocina,
  output logic       armed,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  localparam int unsigned MAX_CYC = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
  localparam int unsigned TRW     = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0]  EXIT_LAST  = TW'(EXIT_CYCLES - 1);
  localparam logic [TW-1:0]  ENTRY_LAST = TW'(ENTRY_CYCLES - 1);
  localparam logic [TRW-1:0] TRIES_MAX  = TRW'(MAX_TRIES);

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [TRW-1:0] tries_q, tries_d;
  logic [15:0]    buf_q, buf_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           alerta_q, alerta_d;
  logic           bocina_q, bocina_d;
  logic           armed_q, armed_d;

  logic           is_digit, is_enter, is_clear;
  logic           enter_ok, enter_bad;
  logic [TRW-1:0] tries_inc;
  logic           siren_d;

`ifdef SIREN_TONE_EN
  localparam int unsigned NW = $clog2(TONE_HALF) + 1;
  localparam logic [NW-1:0] TONE_LAST = NW'(TONE_HALF - 1);
  logic [NW-1:0] tone_q, tone_d;
  logic          siren_q;
`endif

  // Key decode; LOCKOUT ignores the keypad completely.
  always_comb begin
    is_digit  = key_valid && (key_code <= 4'd9) && (state_q != S_LOCKOUT);
    is_enter  = key_valid && (key_code == 4'hE) && (state_q != S_LOCKOUT);
    is_clear  = key_valid && (key_code == 4'hF) && (state_q != S_LOCKOUT);
    enter_ok  = is_enter && (cnt_q == 3'd4) && (buf_q == CODE);
    enter_bad = is_enter && !enter_ok;
    tries_inc = (tries_q == TRIES_MAX) ? tries_q : tries_q + 1'b1;
  end

  // Next-state logic. Buffer updates are computed first; state transitions
  // that must clear the buffer override them further down.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tries_d = tries_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;

    if (is_digit) begin
      buf_d = {buf_q[11:0], key_code};
      cnt_d = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
    end else if (is_clear || is_enter) begin
      buf_d = '0;
      cnt_d = '0;
    end

    case (state_q)
      S_DISARMED: begin
        if (arm_req) begin
          state_d = S_EXIT;
          timer_d = '0;
        end
      end

      S_EXIT, S_ENTRY: begin
        // Priority: correct code, then lockout, then timer expiry.
        if (enter_ok) begin
          state_d = S_DISARMED;
        end else if (enter_bad && (tries_inc == TRIES_MAX)) begin
          tries_d = tries_inc;
          state_d = S_LOCKOUT;
          timer_d = '0;
        end else begin
          if (enter_bad) tries_d = tries_inc;
          if (timer_q == ((state_q == S_EXIT) ? EXIT_LAST : ENTRY_LAST)) begin
            state_d = (state_q == S_EXIT) ? S_ARMED : S_ALARM;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (!pir_n) begin
          state_d = S_ENTRY;
          timer_d = '0;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end

      S_ALARM: begin
        if (enter_ok) begin
          state_d = S_DISARMED;
        end else if (enter_bad) begin
          tries_d = tries_inc;
          if (tries_inc == TRIES_MAX) begin
            state_d = S_LOCKOUT;
            timer_d = '0;
          end
        end
      end

      S_LOCKOUT: begin
        if (timer_q == ENTRY_LAST) begin
          state_d = S_ALARM;
          tries_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: state_d = S_DISARMED;
    endcase

    if (state_d == S_DISARMED) begin
      timer_d = '0;
      tries_d = '0;
      buf_d   = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are derived from the next state so the registered values line
  // up with state_o in the same cycle.
  always_comb begin
    alerta_d = (state_d == S_ENTRY) || (state_d == S_ALARM) || (state_d == S_LOCKOUT);
    armed_d  = (state_d == S_EXIT) || (state_d == S_ARMED) ||
               (state_d == S_ENTRY) || (state_d == S_ALARM);
    siren_d  = (state_d == S_ALARM) || (state_d == S_LOCKOUT);
`ifdef SIREN_TONE_EN
    siren_q  = (state_q == S_ALARM) || (state_q == S_LOCKOUT);
    tone_d   = '0;
    bocina_d = 1'b0;
    if (siren_d) begin
      if (!siren_q) begin
        bocina_d = 1'b1;
      end else if (tone_q == TONE_LAST) begin
        bocina_d = !bocina_q;
      end else begin
        bocina_d = bocina_q;
        tone_d   = tone_q + 1'b1;
      end
    end
`else
    bocina_d = siren_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_DISARMED;
      timer_q  <= '0;
      tries_q  <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      alerta_q <= 1'b0;
      bocina_q <= 1'b0;
      armed_q  <= 1'b0;
`ifdef SIREN_TONE_EN
      tone_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tries_q  <= tries_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      alerta_q <= alerta_d;
      bocina_q <= bocina_d;
      armed_q  <= armed_d;
`ifdef SIREN_TONE_EN
      tone_q   <= tone_d;
`endif
    end
  end

  assign alerta  = alerta_q;
  assign bocina  = bocina_q;
  assign armed   = armed_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pir_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       arm_req;
  logic       alerta;
  logic       bocina;
  logic       armed;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_sequencer #(
    .CODE         (16'h1234),
    .EXIT_CYCLES  (8),
    .ENTRY_CYCLES (20),
    .TONE_HALF    (3),
    .MAX_TRIES    (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pir_n     (pir_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .arm_req   (arm_req),
    .alerta    (alerta),
    .bocina    (bocina),
    .armed     (armed),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic code_enter(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    press(v[15:12]);
    press(v[11:8]);
    press(v[7:4]);
    press(v[3:0]);
    press(4'hE);
  endtask

  // arm_req, then a full exit delay; ends in ARMED
  task automatic arm_to_armed(input string tag);
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    check({tag, "_exit"}, state_o, 3'd1);
    ticks(7);
    check({tag, "_exit_last"}, state_o, 3'd1);
    tick();
    check({tag, "_armed"}, state_o, 3'd2);
  endtask

  task automatic motion();
    pir_n = 1'b0;
    tick();
    pir_n = 1'b1;
  endtask

  initial begin
    logic exp_b;
    reset_n   = 1'b0;
    pir_n     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    arm_req   = 1'b0;
    ticks(2);
    check("rst_state", state_o, 3'd0);
    check("rst_alerta", alerta, 1'b0);
    check("rst_bocina", bocina, 1'b0);
    check("rst_armed", armed, 1'b0);
    reset_n = 1'b1;

    // Disarmed: motion and keys cause no transition
    motion();
    check("dis_pir", state_o, 3'd0);
    code_enter(16'h1234);
    check("dis_keys", state_o, 3'd0);

    // Arm, exit delay with motion ignored, then ARMED
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    check("exit_state", state_o, 3'd1);
    check("exit_armed", armed, 1'b1);
    pir_n = 1'b0;
    ticks(3);
    pir_n = 1'b1;
    check("exit_pir_ign", state_o, 3'd1);
    ticks(4);
    check("exit_last", state_o, 3'd1);
    tick();
    check("armed_state", state_o, 3'd2);
    check("armed_armed", armed, 1'b1);
    check("armed_alerta", alerta, 1'b0);

    // Motion, correct code within window
    motion();
    check("entry_state", state_o, 3'd3);
    check("entry_alerta", alerta, 1'b1);
    check("entry_bocina", bocina, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] c;
      c = 16'h1234;
      press(c[15-4*i -: 4]);
      check("entry_keys_bocina", bocina, 1'b0);
    end
    press(4'hE);
    check("entry_ok_state", state_o, 3'd0);
    check("entry_ok_alerta", alerta, 1'b0);
    check("entry_ok_bocina", bocina, 1'b0);
    check("entry_ok_armed", armed, 1'b0);

    // Correct code during exit delay disarms
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    code_enter(16'h1234);
    check("exit_disarm", state_o, 3'd0);

    // Entry window expires -> ALARM, siren waveform
    arm_to_armed("a2");
    motion();
    ticks(19);
    check("entry_last", state_o, 3'd3);
    tick();
    check("alarm_state", state_o, 3'd4);
    check("alarm_alerta", alerta, 1'b1);
    check("alarm_armed", armed, 1'b1);
    for (int i = 0; i < 6; i++) begin
`ifdef SIREN_TONE_EN
      exp_b = ((i / 3) % 2) == 0;
`else
      exp_b = 1'b1;
`endif
      check("alarm_bocina", bocina, exp_b);
      tick();
    end
    check("alarm_bocina_hi", bocina, 1'b1);

    // Reset mid-alarm
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_alarm_state", state_o, 3'd0);
    check("rst_alarm_bocina", bocina, 1'b0);
    check("rst_alarm_alerta", alerta, 1'b0);

    // Three wrong codes in ENTRY -> LOCKOUT
    arm_to_armed("a3");
    motion();
    code_enter(16'h1111);
    check("wrong1", state_o, 3'd3);
    code_enter(16'h1111);
    check("wrong2", state_o, 3'd3);
    code_enter(16'h1111);
    check("lock_state", state_o, 3'd5);
    check("lock_alerta", alerta, 1'b1);
    check("lock_bocina", bocina, 1'b1);
    check("lock_armed", armed, 1'b0);
    code_enter(16'h1234);
    check("lock_keys_ign", state_o, 3'd5);
    ticks(14);
    check("lock_last", state_o, 3'd5);
    tick();
    check("lock_to_alarm", state_o, 3'd4);
    // tries were cleared: one wrong ENTER must not re-lock
    press(4'hE);
    check("alarm_wrong1", state_o, 3'd4);
    code_enter(16'h1234);
    check("alarm_disarm", state_o, 3'd0);
    check("alarm_disarm_alerta", alerta, 1'b0);
    check("alarm_disarm_bocina", bocina, 1'b0);

    // Correct ENTER on the final entry-window cycle wins
    arm_to_armed("a4");
    motion();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    ticks(15);
    press(4'h4);
    check("race_pre", state_o, 3'd3);
    press(4'hE);
    check("race_state", state_o, 3'd0);
    check("race_alerta", alerta, 1'b0);

    // Five digits: oldest discarded
    arm_to_armed("a5");
    motion();
    press(4'h9);
    code_enter(16'h1234);
    check("five_digits", state_o, 3'd0);

    // CLEAR mid-entry leaves only two digits -> wrong
    arm_to_armed("a6");
    motion();
    press(4'h1);
    press(4'h2);
    press(4'hF);
    press(4'h3);
    press(4'h4);
    press(4'hE);
    check("clear_wrong", state_o, 3'd3);
    code_enter(16'h1234);
    check("clear_then_ok", state_o, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
